// File: rtl/sram_1rw_arbiter_pkg.sv
// Shared types and default sizes for the single-port SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

    // Controller state: zero-fill after reset, then serve requests.
    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_e;

    // Which requester got the macro; also the round-robin memory.
    typedef enum logic {
        GNT_RD,
        GNT_WR
    } grant_e;

    localparam int DATA_W_DEF = 144;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/sram_1rw_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: write request, read request, read response.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both request channels; the response channel has no ready.
interface sram_1rw_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_resp_valid, rd_resp_data
    );
endinterface

// File: rtl/sram_1rw_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = read, bit 1 = write, one-hot grant out.
// Latency: grant is combinational from req_i; last-grant memory updates on the clock edge.
// Backpressure: grants nothing while en_i is low; a lone request always wins.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    grant_e last_q, last_d;

    // Grant selection; only a contested grant moves the round-robin pointer.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11: begin
                    if (last_q == GNT_RD) begin
                        gnt_o  = 2'b10;
                        last_d = GNT_WR;
                    end else begin
                        gnt_o  = 2'b01;
                        last_d = GNT_RD;
                    end
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Round-robin memory; starts at read so the first conflict goes to the writer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one 1RW SRAM macro (active-low CEB/WEB) between a write and a read requester, round-robin.
// Latency: macro pins follow the grant in the same cycle; read data returns one cycle after grant, then held.
// Backpressure: one request accepted per cycle; readys low in reset and INIT. Macro SRAM_ARB_INIT_EN adds post-reset zero-fill.
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_1rw_arbiter_if.slave req,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic              active;
    logic              any_vld;
    logic [1:0]        gnt;
    logic              wr_fire, rd_fire;
    logic              wr_in_rng, rd_in_rng;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] hold_q;
    logic              resp_vld_q;
    logic              resp_zero_q;
`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

    // Readys and macro pins are combinational, so reset_n gates them to keep reset values on the pins.
    assign active    = reset_n && (state_q == S_IDLE);
    assign init_done = active;
    assign any_vld   = req.wr_valid | req.rd_valid;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (active),
        .req_i   ({req.wr_valid, req.rd_valid}),
        .gnt_o   (gnt)
    );

    // With nothing pending both readys are high, so a new request never waits on the other side.
    assign req.wr_ready = active && (gnt[1] || !any_vld);
    assign req.rd_ready = active && (gnt[0] || !any_vld);
    assign wr_fire      = req.wr_valid && req.wr_ready;
    assign rd_fire      = req.rd_valid && req.rd_ready;
    assign wr_in_rng    = {1'b0, req.wr_addr} < DEPTH_L;
    assign rd_in_rng    = {1'b0, req.rd_addr} < DEPTH_L;

    // Next state and macro drive; out-of-range requests are accepted but never touch the macro.
    always_comb begin
        state_d  = state_q;
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = a_q;
        sram_d   = d_q;
`ifdef SRAM_ARB_INIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_INIT: begin
`ifdef SRAM_ARB_INIT_EN
                if (reset_n) begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = cnt_q;
                    sram_d   = '0;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = S_IDLE;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (wr_fire && wr_in_rng) begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = req.wr_addr;
                    sram_d   = req.wr_data;
                end else if (rd_fire && rd_in_rng) begin
                    sram_ceb = 1'b0;
                    sram_a   = req.rd_addr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register (and zero-fill counter when built in).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef SRAM_ARB_INIT_EN
            state_q <= S_INIT;
            cnt_q   <= '0;
`else
            state_q <= S_IDLE;
`endif
        end else begin
            state_q <= state_d;
`ifdef SRAM_ARB_INIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Remember the last address/data driven so idle cycles do not toggle the macro inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= sram_a;
            d_q <= sram_d;
        end
    end

    // Response pulse one cycle after a read grant; Q is captured so later cycles never show raw Q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_vld_q  <= 1'b0;
            resp_zero_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            resp_vld_q  <= rd_fire;
            resp_zero_q <= !rd_in_rng;
            if (resp_vld_q) begin
                hold_q <= req.rd_resp_data;
            end
        end
    end

    assign req.rd_resp_valid = resp_vld_q;
    assign req.rd_resp_data  = resp_vld_q ? (resp_zero_q ? '0 : sram_q) : hold_q;
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter with a behavioural 1RW macro (random Q on non-read cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_1rw_arbiter;
    localparam int DW    = 144;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          known;
    } rsp_t;

    typedef struct {
        logic wv;
        logic rv;
        logic exp_wr;
        logic exp_rd;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    sram_1rw_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_1rw_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (bus),
        .init_done (init_done),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mem [8];
    logic [DW-1:0] shadow [DEPTH];
    bit            shadow_known [DEPTH];
    rsp_t          exp_q [$];
    logic          pend_rd;
    logic [DW-1:0] last_resp;
    logic          last_known;
    logic          in_init;
    logic          last_wf, last_rf;
    vec_t          vecs [15];

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Macro model: write on CEB=0/WEB=0, Q valid the cycle after a read, garbage otherwise.
    always @(posedge clock) begin
        if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
        if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
        else                       sram_q <= rand_word();
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
        end
    endtask

    task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, score response and macro pins.
    task automatic cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra);
        rsp_t e;
        logic wf, rf;
        @(negedge clock);
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        #1;
        chk1("resp_valid", bus.rd_resp_valid, pend_rd);
        if (pend_rd) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.known) chkd("resp_data", bus.rd_resp_data, e.data);
                last_resp  = e.data;
                last_known = e.known;
            end
        end else if (last_known) begin
            chkd("resp_hold", bus.rd_resp_data, last_resp);
        end
        wf = wv && bus.wr_ready;
        rf = rv && bus.rd_ready;
        chk1("single_accept", wf && rf, 1'b0);
        if (!in_init) begin
            if (wf && int'(wa) < DEPTH) begin
                chk1("wr_ceb", sram_ceb, 1'b0);
                chk1("wr_web", sram_web, 1'b0);
                chka("wr_a", sram_a, wa);
                chkd("wr_d", sram_d, wd);
            end else if (rf && int'(ra) < DEPTH) begin
                chk1("rd_ceb", sram_ceb, 1'b0);
                chk1("rd_web", sram_web, 1'b1);
                chka("rd_a", sram_a, ra);
            end else begin
                chk1("idle_ceb", sram_ceb, 1'b1);
            end
        end
        if (wf && int'(wa) < DEPTH) begin
            shadow[wa]       = wd;
            shadow_known[wa] = 1'b1;
        end
        if (rf) begin
            if (int'(ra) < DEPTH) exp_q.push_back('{data: shadow[ra], known: shadow_known[ra]});
            else                  exp_q.push_back('{data: '0, known: 1'b1});
        end
        pend_rd = rf;
        last_wf = wf;
        last_rf = rf;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Assert reset mid-cycle with both valids high; everything must drop to reset values.
    task automatic do_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        bus.wr_valid = 1'b1;
        bus.rd_valid = 1'b1;
        #1;
        chk1("rst_resp_valid", bus.rd_resp_valid, 1'b0);
        chkd("rst_resp_data", bus.rd_resp_data, '0);
        chk1("rst_ceb", sram_ceb, 1'b1);
        chk1("rst_web", sram_web, 1'b1);
        chka("rst_a", sram_a, '0);
        chkd("rst_d", sram_d, '0);
        chk1("rst_wr_ready", bus.wr_ready, 1'b0);
        chk1("rst_rd_ready", bus.rd_ready, 1'b0);
        chk1("rst_init_done", init_done, 1'b0);
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        exp_q.delete();
        pend_rd    = 1'b0;
        last_resp  = '0;
        last_known = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic post_reset_init();
`ifdef SRAM_ARB_INIT_EN
        in_init = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 3'd2, rand_word(), 1'b1, 3'd2);
            chk1("init_done_low", init_done, 1'b0);
            chk1("init_wr_ready", bus.wr_ready, 1'b0);
            chk1("init_rd_ready", bus.rd_ready, 1'b0);
            chk1("init_ceb", sram_ceb, 1'b0);
            chk1("init_web", sram_web, 1'b0);
            chka("init_a", sram_a, AW'(i));
            chkd("init_d", sram_d, '0);
        end
        in_init = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            shadow[i]       = '0;
            shadow_known[i] = 1'b1;
        end
`endif
        idle_cycle();
        chk1("init_done_high", init_done, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] dk [3];
        logic [7:0]    pat;
        a5 = {18{8'hA5}};
        // {wr_valid, rd_valid, expected wr_ready, expected rd_ready}, starting from last grant = read
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 8; i++) mem[i] = rand_word();
        for (int i = 0; i < DEPTH; i++) shadow_known[i] = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        in_init      = 1'b0;
        pend_rd      = 1'b0;
        last_resp    = '0;
        last_known   = 1'b1;
        reset_n      = 1'b1;
        #2 reset_n   = 1'b0;

        do_reset();
        post_reset_init();

        // Read addr 5 straight after init (zero when the fill is built in).
        cycle(1'b0, '0, '0, 1'b1, 3'd5);
        chk1("rd5_accept", last_rf, 1'b1);
        idle_cycle();
        chk1("rd5_resp", bus.rd_resp_valid, 1'b1);

        // Arbitration table, all traffic on addr 1.
        for (int i = 0; i < 15; i++) begin
            pat = 8'(8'h10 + i);
            cycle(vecs[i].wv, 3'd1, {18{pat}}, vecs[i].rv, 3'd1);
            chk1($sformatf("arb%0d_wr_ready", i), bus.wr_ready, vecs[i].exp_wr);
            chk1($sformatf("arb%0d_rd_ready", i), bus.rd_ready, vecs[i].exp_rd);
        end
        idle_cycle();

        // Write then read, then hold over idle cycles while Q is garbage.
        cycle(1'b1, 3'd3, a5, 1'b0, '0);
        chk1("a5_wr_accept", last_wf, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 3'd3);
        chk1("a5_rd_accept", last_rf, 1'b1);
        idle_cycle();
        chk1("a5_resp_valid", bus.rd_resp_valid, 1'b1);
        chkd("a5_resp_data", bus.rd_resp_data, a5);
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            chk1("a5_hold_valid", bus.rd_resp_valid, 1'b0);
            chkd("a5_hold_data", bus.rd_resp_data, a5);
        end

        // Streaming reads of addr 0,1,2.
        for (int k = 0; k < 3; k++) begin
            dk[k] = rand_word();
            cycle(1'b1, AW'(k), dk[k], 1'b0, '0);
        end
        cycle(1'b0, '0, '0, 1'b1, 3'd0);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) cycle(1'b0, '0, '0, 1'b1, AW'(k + 1));
            else       idle_cycle();
            chk1($sformatf("stream%0d_valid", k), bus.rd_resp_valid, 1'b1);
            chkd($sformatf("stream%0d_data", k), bus.rd_resp_data, dk[k]);
        end
        idle_cycle();
        chk1("stream_end", bus.rd_resp_valid, 1'b0);

        // Out-of-range addresses 7 and 6.
        cycle(1'b1, 3'd7, rand_word(), 1'b0, '0);
        chk1("oor7_wr_accept", last_wf, 1'b1);
        chk1("oor7_wr_ceb", sram_ceb, 1'b1);
        cycle(1'b1, 3'd6, rand_word(), 1'b0, '0);
        chk1("oor6_wr_ceb", sram_ceb, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 3'd7);
        chk1("oor7_rd_accept", last_rf, 1'b1);
        chk1("oor7_rd_ceb", sram_ceb, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 3'd6);
        chk1("oor7_resp_valid", bus.rd_resp_valid, 1'b1);
        chkd("oor7_resp_zero", bus.rd_resp_data, '0);
        idle_cycle();
        chk1("oor6_resp_valid", bus.rd_resp_valid, 1'b1);
        chkd("oor6_resp_zero", bus.rd_resp_data, '0);

        // Reset in the cycle after a read grant drops the response.
        cycle(1'b0, '0, '0, 1'b1, 3'd3);
        chk1("rst_rd_accept", last_rf, 1'b1);
        do_reset();
        post_reset_init();
        cycle(1'b0, '0, '0, 1'b1, 3'd3);
        chk1("post_rst_rd_accept", last_rf, 1'b1);
        idle_cycle();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
